// File: rtl/decoder_mul_share_arb_if.sv
// Operand-request and product-response bundle for the shared multiplier.
// Handshake rule for both channels: a transfer happens on the rising clock edge where valid && ready are both high.
interface decoder_mul_share_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 8,
  parameter int P_WIDTH  = 24,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [P_WIDTH-1:0]         rsp_product;
  logic [ID_WIDTH-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id
  );
endinterface

// File: rtl/decoder_mul_share_arb.sv
// Round-robin arbiter time-sharing one signed A x B multiplier among NUM_REQ requesters.
// Two stages: S1 holds the granted operands, S2 holds the product and drives the response channel.
module decoder_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 8,
  parameter int P_WIDTH  = 24,
  parameter int ID_WIDTH = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  decoder_mul_share_arb_if.slave  bus,
  output logic                    busy
);
  localparam int F_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0] a_arr [NUM_REQ];
  logic signed [B_WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*A_WIDTH +: A_WIDTH];
    assign b_arr[i] = bus.req_b[i*B_WIDTH +: B_WIDTH];
  end

  logic [ID_WIDTH-1:0]       rr_ptr;
  logic                      s1_valid;
  logic signed [A_WIDTH-1:0] s1_a;
  logic signed [B_WIDTH-1:0] s1_b;
  logic [ID_WIDTH-1:0]       s1_id;
  logic                      s2_valid;
  logic [P_WIDTH-1:0]        s2_product;
  logic [ID_WIDTH-1:0]       s2_id;

  logic s2_adv;
  logic s1_adv;
  assign s2_adv = !s2_valid || bus.rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  logic                      found;
  logic                      grant;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic [ID_WIDTH:0]         sum;

  // Search from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (sum >= (ID_WIDTH+1)'(NUM_REQ)) sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      if (!found && bus.req_valid[sum[ID_WIDTH-1:0]]) begin
        found     = 1'b1;
        grant_idx = sum[ID_WIDTH-1:0];
      end
    end
  end

  // Reset gating keeps req_ready low while ap_rst_n is asserted.
  assign grant = found && s1_adv && ap_rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      if (grant) begin
        s1_valid <= 1'b1;
        s1_a     <= a_arr[grant_idx];
        s1_b     <= b_arr[grant_idx];
        s1_id    <= grant_idx;
        rr_ptr   <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + ID_WIDTH'(1);
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Signed operands in an F_WIDTH context give the exact product; keep its low P_WIDTH bits.
  logic signed [F_WIDTH-1:0] full_prod;
  assign full_prod = s1_a * s1_b;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid   <= 1'b0;
      s2_product <= '0;
      s2_id      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_product <= full_prod[P_WIDTH-1:0];
        s2_id      <= s1_id;
      end
    end
  end

  assign bus.rsp_valid   = s2_valid;
  assign bus.rsp_product = s2_product;
  assign bus.rsp_id      = s2_id;
  assign busy            = s1_valid || s2_valid;
endmodule

// File: tb/tb_decoder_mul_share_arb.sv
// Bench for decoder_mul_share_arb: queue-based capacity-2 model checked every cycle,
// plus directed sequences with hand-computed products and grant orders.
module tb_decoder_mul_share_arb;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 8;
  localparam int PW = 24;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic busy;
  always #5 ap_clk = ~ap_clk;

  decoder_mul_share_arb_if #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)) bus ();

  decoder_mul_share_arb #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Items in flight, oldest first; an item accepted at edge e is visible from edge e+2 on.
  logic [PW-1:0] exp_q[$];
  int            exp_id_q[$];
  int            exp_edge_q[$];
  int            rr       = 0;
  int            cur_edge = 0;
  bit            pend_pop = 0;
  int            pend_g   = -1;
  logic [AW-1:0] pend_a;
  logic [BW-1:0] pend_b;

  int            grant_log[$];
  int            obs_id[$];
  logic [PW-1:0] obs_prod[$];

  function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[PW-1:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_id_q.delete();
    exp_edge_q.delete();
    rr       = 0;
    cur_edge = 0;
    pend_pop = 0;
    pend_g   = -1;
  endtask

  always @(negedge ap_rst_n) model_clear();

  // Compare process: inputs are stable here (driven 1 time unit after posedge).
  always @(negedge ap_clk) begin
    bit            vis;
    bit            can;
    int            g;
    logic [N-1:0]  exp_ready;
    if (!ap_rst_n) begin
      model_clear();
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_product", bus.rsp_product, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
    end else begin
      vis = (exp_q.size() > 0) && (exp_edge_q[0] <= cur_edge - 2);
      can = (exp_q.size() < 2) || (vis && bus.rsp_ready);
      g   = -1;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("rsp_valid", bus.rsp_valid, vis);
      if (vis) begin
        chk("rsp_product", bus.rsp_product, exp_q[0]);
        chk("rsp_id", bus.rsp_id, exp_id_q[0]);
      end
      chk("busy", busy, exp_q.size() > 0);
      chk("req_ready", bus.req_ready, exp_ready);
      chk("req_ready_onehot0", $onehot0(bus.req_ready), 1);
      pend_pop = vis && bus.rsp_ready;
      pend_g   = g;
      if (g >= 0) begin
        pend_a = bus.req_a[g*AW +: AW];
        pend_b = bus.req_b[g*BW +: BW];
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);
      if (bus.rsp_valid && bus.rsp_ready) begin
        obs_id.push_back(int'(bus.rsp_id));
        obs_prod.push_back(bus.rsp_product);
      end
    end
  end

  always @(posedge ap_clk) begin
    if (ap_rst_n) begin
      if (pend_pop) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(exp_edge_q.pop_front());
      end
      if (pend_g >= 0) begin
        exp_q.push_back(ref_mul(pend_a, pend_b));
        exp_id_q.push_back(pend_g);
        exp_edge_q.push_back(cur_edge);
        rr = (pend_g + 1) % N;
      end
      cur_edge++;
      pend_pop = 0;
      pend_g   = -1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[i*AW +: AW]  = a;
    bus.req_b[i*BW +: BW]  = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    obs_id.delete();
    obs_prod.delete();
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
  endtask

  // Fixed per-requester operands used by the streaming tests, with hand-computed products.
  task automatic set_all_fixed();
    set_req(0, -16'sd5, 8'sd7);      // -35    -> 0xFFFFDD
    set_req(1, 16'sd1000, -8'sd3);   // -3000  -> 0xFFF448
    set_req(2, 16'sd300, 8'sd100);   // 30000  -> 0x007530
    set_req(3, -16'sd1, -8'sd1);     // 1      -> 0x000001
  endtask

  function automatic logic [PW-1:0] fixed_prod(input int id);
    case (id)
      0:       return 24'hFFFFDD;
      1:       return 24'hFFF448;
      2:       return 24'h007530;
      default: return 24'h000001;
    endcase
  endfunction

  logic [PW-1:0] hold_p;
  logic [IW-1:0] hold_id;

  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    ap_rst_n      = 1'b0;

    // Reset state, with every requester valid to confirm req_ready stays low.
    repeat (3) step();
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_product", bus.rsp_product, 0);
    chk("reset_busy", busy, 0);
    clear_reqs();
    ap_rst_n = 1'b1;
    step();

    // Single request from requester 2.
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_req(2, 16'h8000, 8'h80);
    step();
    clear_reqs();
    chk("single_grant_count", grant_log.size(), 1);
    chk("single_grant_id", grant_log[0], 2);
    step();
    chk("single_latency_valid", bus.rsp_valid, 1);
    repeat (3) step();
    chk("single_rsp_count", obs_id.size(), 1);
    chk("single_product", obs_prod[0], 24'h400000);
    chk("single_id", obs_id[0], 2);

    // Round-robin with all requesters valid.
    do_reset();
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_all_fixed();
    repeat (6) step();
    clear_reqs();
    repeat (4) step();
    chk("rr_rsp_count", obs_id.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_id_seq", obs_id[i], i % 4);
    chk("rr_prod_r0", obs_prod[0], 24'hFFFFDD);
    chk("rr_prod_r1", obs_prod[1], 24'hFFF448);
    chk("rr_prod_r2", obs_prod[2], 24'h007530);
    chk("rr_prod_r3", obs_prod[3], 24'h000001);

    // Backpressure mid-stream.
    do_reset();
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_all_fixed();
    repeat (4) step();
    bus.rsp_ready = 1'b0;
    @(negedge ap_clk);
    hold_p  = bus.rsp_product;
    hold_id = bus.rsp_id;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge ap_clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_product_stable", bus.rsp_product, hold_p);
      chk("bp_id_stable", bus.rsp_id, hold_id);
      chk("bp_req_ready_zero", bus.req_ready, 0);
    end
    @(posedge ap_clk);
    #1;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    clear_reqs();
    repeat (5) step();
    chk("bp_no_loss_dup", obs_id.size(), grant_log.size());
    for (int i = 0; i < obs_id.size(); i++) begin
      chk("bp_order_id", obs_id[i], i % 4);
      chk("bp_order_prod", obs_prod[i], fixed_prod(i % 4));
    end

    // Sparse requesters 3 and 0, starting from rr_ptr = 1.
    do_reset();
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_req(0, 16'sd2, 8'sd2);
    step();
    clear_reqs();
    repeat (3) step();
    set_req(3, 16'sd9, -8'sd9);
    set_req(0, -16'sd4, 8'sd11);
    repeat (4) step();
    clear_reqs();
    repeat (4) step();
    chk("sparse_grant_count", grant_log.size(), 5);
    chk("sparse_g1", grant_log[1], 3);
    chk("sparse_g2", grant_log[2], 0);
    chk("sparse_g3", grant_log[3], 3);
    chk("sparse_g4", grant_log[4], 0);
    chk("sparse_prod_r3", obs_prod[1], 24'hFFFFAF);

    // Asynchronous reset with both stages full.
    bus.rsp_ready = 1'b0;
    set_all_fixed();
    repeat (3) step();
    chk("midrst_busy_before", busy, 1);
    @(negedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    clear_reqs();
    repeat (2) step();
    ap_rst_n = 1'b1;
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_req(1, 16'sd32767, 8'sd127);
    set_req(3, 16'sd2, 8'sd3);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    clear_reqs();
    repeat (4) step();
    chk("postrst_first_grant", grant_log[0], 1);
    chk("postrst_product", obs_prod[0], 24'h3F7F81);
    chk("postrst_id", obs_id[0], 1);
    chk("postrst_second_id", obs_id[1], 3);

    // Random valid / rsp_ready traffic checked by the model every cycle.
    clear_logs();
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        bus.req_a[i*AW +: AW] = AW'($urandom_range(0, 65535));
        bus.req_b[i*BW +: BW] = BW'($urandom_range(0, 255));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    clear_reqs();
    bus.rsp_ready = 1'b1;
    repeat (5) step();
    chk("rand_no_loss_dup", obs_id.size(), grant_log.size());
    chk("rand_drained_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
